seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector; successor to the team's fixed 4-bit Mealy detector.

---
 rtl/seq_det_pkg.sv | 16 +
 rtl/seq_detector_param_if.sv | 26 ++
 rtl/sat_counter.sv | 23 ++
 rtl/seq_detector_param.sv | 87 ++++++++
 tb/tb_seq_detector_param.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised sequence detector.
package seq_det_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam logic [3:0] SEQ_DEFAULT_PAT = 4'b1101;

  // Width needed for a counter that runs 0..pat_w inclusive.
  function automatic int unsigned fill_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial-in / match-out bundle of the sequence detector.
interface seq_detector_param_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             x;
  logic             x_valid;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic             z;
  logic [PAT_W-1:0] seq;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  modport master (
    output x, x_valid, overlap, pat_load, pat_in, cnt_clr,
    input  z, seq, match_cnt, armed
  );

  modport slave (
    input  x, x_valid, overlap, pat_load, pat_in, cnt_clr,
    output z, seq, match_cnt, armed
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Count events, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: history shift register, loadable pattern,
// fill tracking, FILL/ARMED FSM, match strobe and saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(SEQ_DEFAULT_PAT),
  parameter int unsigned      CNT_W       = 8,
  parameter bit               REG_OUT     = 1'b1
) (
  input logic clk,
  input logic rst,
  seq_detector_param_if.slave bus
);

  localparam int unsigned FW = fill_w(PAT_W);

  logic [PAT_W-1:0] r_seq;
  logic [PAT_W-1:0] r_pat;
  logic [FW-1:0]    r_fill;
  state_e           r_state;
  logic [PAT_W-1:0] w_next_seq;
  logic             w_hit;
  logic [CNT_W-1:0] w_cnt;

  assign w_next_seq = {r_seq[PAT_W-2:0], bus.x};

  // A match needs PAT_W-1 prior bits plus the bit arriving on this edge.
  assign w_hit = bus.x_valid & ~bus.pat_load
               & (r_fill >= FW'(PAT_W - 1))
               & (w_next_seq == r_pat);

  // History, pattern, fill counter and FILL/ARMED state in one sequential block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seq   <= '0;
      r_pat   <= DEFAULT_PAT;
      r_fill  <= '0;
      r_state <= FILL;
    end else if (bus.pat_load) begin
      r_pat   <= bus.pat_in;
      r_seq   <= '0;
      r_fill  <= '0;
      r_state <= FILL;
    end else if (bus.x_valid) begin
      r_seq <= w_next_seq;
      if (w_hit && !bus.overlap) begin
        // Non-overlapping: the matched bits stay visible in seq but do not count again.
        r_fill  <= '0;
        r_state <= FILL;
      end else begin
        if (r_fill != FW'(PAT_W)) begin
          r_fill <= r_fill + FW'(1);
        end
        if (r_fill >= FW'(PAT_W - 1)) begin
          r_state <= ARMED;
        end
      end
    end
  end

  // Match count for the display.
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_hit),
    .clr (bus.cnt_clr),
    .cnt (w_cnt)
  );

  assign bus.match_cnt = w_cnt;
  assign bus.seq       = r_seq;
  assign bus.armed     = (r_state == ARMED);

  if (REG_OUT) begin : g_zreg
    logic r_z;
    // Registered strobe: high for the cycle after the final bit's edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_z <= 1'b0;
      else     r_z <= w_hit;
    end
    assign bus.z = r_z;
  end else begin : g_zcomb
    assign bus.z = w_hit;
  end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;
  localparam int PAT_W = 4;

  logic clk;
  logic rst;

  seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) bus1 ();
  seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) bus2 ();

  seq_detector_param #(.PAT_W(4), .CNT_W(8), .REG_OUT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(2), .REG_OUT(1'b0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: bits since last restart (q), bits since reset/load (hist).
  bit       q[$];
  bit       hist[$];
  bit [3:0] m_pat;
  int       m_cnt8;
  int       m_cnt2;
  bit       m_z;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hist.delete();
    m_pat  = 4'b1101;
    m_cnt8 = 0;
    m_cnt2 = 0;
    m_z    = 1'b0;
  endtask

  function automatic bit model_hit(input bit x, input bit v, input bit ld);
    if (ld || !v) return 1'b0;
    if (q.size() < PAT_W - 1) return 1'b0;
    for (int i = 0; i < PAT_W - 1; i++)
      if (q[q.size() - (PAT_W - 1) + i] != m_pat[PAT_W - 1 - i]) return 1'b0;
    return x == m_pat[0];
  endfunction

  function automatic logic [31:0] exp_seq();
    logic [31:0] s = 0;
    foreach (hist[k]) s = (s << 1) | 32'(hist[k]);
    return s;
  endfunction

  task automatic check_outputs();
    check_val("z_reg", 32'(bus1.z), 32'(m_z));
    check_val("seq1", 32'(bus1.seq), exp_seq());
    check_val("seq2", 32'(bus2.seq), exp_seq());
    check_val("cnt8", 32'(bus1.match_cnt), 32'(m_cnt8));
    check_val("cnt2", 32'(bus2.match_cnt), 32'(m_cnt2));
    check_val("armed1", 32'(bus1.armed), 32'(q.size() >= PAT_W));
    check_val("armed2", 32'(bus2.armed), 32'(q.size() >= PAT_W));
  endtask

  task automatic drive(input bit x, input bit v, input bit ov, input bit ld,
                       input logic [3:0] pin, input bit clr);
    bus1.x = x; bus1.x_valid = v; bus1.overlap = ov;
    bus1.pat_load = ld; bus1.pat_in = pin; bus1.cnt_clr = clr;
    bus2.x = x; bus2.x_valid = v; bus2.overlap = ov;
    bus2.pat_load = ld; bus2.pat_in = pin; bus2.cnt_clr = clr;
  endtask

  // One clock: called just after a rising edge, returns #1 after the next one.
  task automatic step(input bit x, input bit v, input bit ov, input bit ld,
                      input logic [3:0] pin, input bit clr);
    bit h;
    drive(x, v, ov, ld, pin, clr);
    @(negedge clk);
    h = model_hit(x, v, ld);
    check_val("z_comb", 32'(bus2.z), 32'(h));
    @(posedge clk);
    #1;
    if (ld) begin
      m_pat = pin;
      q.delete();
      hist.delete();
    end else if (v) begin
      hist.push_back(x);
      if (hist.size() > PAT_W) void'(hist.pop_front());
      q.push_back(x);
      if (q.size() > PAT_W) void'(q.pop_front());
    end
    if (clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end
    if (h) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
      if (!ov) q.delete();
    end
    m_z = h;
    check_outputs();
  endtask

  task automatic run_stream(input logic [31:0] bits, input int n, input bit ov, input int clr_at);
    for (int i = 0; i < n; i++)
      step(bits[n - 1 - i], 1'b1, ov, 1'b0, 4'h0, i == clr_at);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    do_reset();

    // 1: overlapping matches of 1101
    run_stream(32'b1101101, 7, 1'b1, -1);
    check_val("t1_z", 32'(bus1.z), 32'd1);
    check_val("t1_cnt", 32'(bus1.match_cnt), 32'd2);
    check_val("t1_armed", 32'(bus1.armed), 32'd1);

    // 2: non-overlapping, second match suppressed
    do_reset();
    run_stream(32'b1101101, 7, 1'b0, -1);
    check_val("t2_z", 32'(bus1.z), 32'd0);
    check_val("t2_cnt", 32'(bus1.match_cnt), 32'd1);
    check_val("t2_armed", 32'(bus1.armed), 32'd0);

    // 3: pattern load mid-fill discards x
    do_reset();
    run_stream(32'b110, 3, 1'b1, -1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    check_val("t3_seq", 32'(bus1.seq), 32'd0);
    check_val("t3_armed", 32'(bus1.armed), 32'd0);
    run_stream(32'b0110, 4, 1'b1, -1);
    check_val("t3_z", 32'(bus1.z), 32'd1);
    check_val("t3_cnt", 32'(bus1.match_cnt), 32'd1);

    // 4: 2-bit counter saturation, clear together with hit
    do_reset();
    run_stream(32'b1101101101101, 13, 1'b1, -1);
    check_val("t4_cnt2_sat", 32'(bus2.match_cnt), 32'd3);
    check_val("t4_cnt8", 32'(bus1.match_cnt), 32'd4);
    run_stream(32'b101, 3, 1'b1, 2);
    check_val("t4_clr_hit2", 32'(bus2.match_cnt), 32'd1);
    check_val("t4_clr_hit8", 32'(bus1.match_cnt), 32'd1);

    // 5: idle cycles inside the pattern
    do_reset();
    begin
      logic [3:0] p = 4'b1101;
      for (int i = 3; i >= 0; i--) begin
        for (int k = 0; k < 2; k++)
          step(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        step(p[i], 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      end
    end
    check_val("t5_z", 32'(bus1.z), 32'd1);
    check_val("t5_seq", 32'(bus1.seq), 32'hD);

    // 6: asynchronous reset between edges
    do_reset();
    run_stream(32'b1101, 4, 1'b1, -1);
    check_val("t6_pre_z", 32'(bus1.z), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_val("t6_z", 32'(bus1.z), 32'd0);
    check_val("t6_seq", 32'(bus1.seq), 32'd0);
    check_val("t6_cnt", 32'(bus1.match_cnt), 32'd0);
    check_val("t6_armed", 32'(bus1.armed), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_stream(32'b1101, 4, 1'b1, -1);
    check_val("t6_defpat", 32'(bus1.z), 32'd1);

    // Random traffic
    begin
      bit ov = 1'b1;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 15) == 0) ov = ~ov;
        step(1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0,
             ov,
             $urandom_range(0, 49) == 0,
             4'($urandom_range(0, 15)),
             $urandom_range(0, 29) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
